// File: rtl/pdm_capture_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pdm_ctrl_pkg
// Shared definitions for the PDM capture controller: host opcodes, status
// byte bit positions, FSM state and TX mode enumerations, and a helper that
// assembles the status byte.
// Optional feature macro: PDM_SAMPLE_COUNT_EN (adds the CMD_COUNT readout).
// ---------------------------------------------------------------------------
package pdm_ctrl_pkg;

  // Host command opcodes
  localparam logic [7:0] CMD_START  = 8'h01;
  localparam logic [7:0] CMD_STOP   = 8'h02;
  localparam logic [7:0] CMD_STATUS = 8'h03;
  localparam logic [7:0] CMD_CLRERR = 8'h05;
  localparam logic [7:0] CMD_COUNT  = 8'h06;

  // Status byte layout: {active, overflow, full, empty, 4'h0}
  localparam int ST_ACTIVE_BIT = 7;
  localparam int ST_OVF_BIT    = 6;
  localparam int ST_FULL_BIT   = 5;
  localparam int ST_EMPTY_BIT  = 4;

  typedef enum logic {
    W_IDLE,
    W_HI
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_LOAD
  } rd_state_t;

  // What the next SPI transfer carries
  typedef enum logic [1:0] {
    DATA,
    STATUS,
    CNT_LO,
    CNT_HI
  } tx_mode_t;

  function automatic logic [7:0] status_byte(input logic active,
                                             input logic ovf,
                                             input logic full,
                                             input logic empty);
    logic [7:0] s;
    s                = '0;
    s[ST_ACTIVE_BIT] = active;
    s[ST_OVF_BIT]    = ovf;
    s[ST_FULL_BIT]   = full;
    s[ST_EMPTY_BIT]  = empty;
    return s;
  endfunction

endpackage

// File: rtl/pdm_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// pdm_capture_ctrl_if
// Bundles the PCM input, SPI slave handshake and TX FIFO signals seen by the
// capture controller.
//   master : the controller (drives FIFO strobes, SPI TX byte, status flags)
//   slave  : the surrounding PCM source, SPI slave and FIFO
// Signals:
//   pcm_valid/pcm_data            PCM sample strobe and 16-bit sample
//   spi_rx_valid/spi_rx_data      host command byte strobe and value
//   spi_xfer_start                start-of-transfer pulse
//   spi_tx_data/spi_tx_valid      preload byte and its load strobe
//   fifo_full/fifo_empty          FIFO flags
//   fifo_rd_data                  FIFO read data (1 cycle after fifo_rd_en)
//   fifo_wr_en/fifo_wr_data       FIFO write port
//   fifo_rd_en                    FIFO read strobe
//   capture_active/overflow       controller status outputs
// ---------------------------------------------------------------------------
interface pdm_capture_ctrl_if;

  logic        pcm_valid;
  logic [15:0] pcm_data;
  logic        spi_rx_valid;
  logic [7:0]  spi_rx_data;
  logic        spi_xfer_start;
  logic [7:0]  spi_tx_data;
  logic        spi_tx_valid;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_rd_data;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic        fifo_rd_en;
  logic        capture_active;
  logic        overflow;

  modport master (
    input  pcm_valid, pcm_data, spi_rx_valid, spi_rx_data, spi_xfer_start,
           fifo_full, fifo_empty, fifo_rd_data,
    output spi_tx_data, spi_tx_valid, fifo_wr_en, fifo_wr_data, fifo_rd_en,
           capture_active, overflow
  );

  modport slave (
    output pcm_valid, pcm_data, spi_rx_valid, spi_rx_data, spi_xfer_start,
           fifo_full, fifo_empty, fifo_rd_data,
    input  spi_tx_data, spi_tx_valid, fifo_wr_en, fifo_wr_data, fifo_rd_en,
           capture_active, overflow
  );

endinterface

// File: rtl/pdm_capture_ctrl_pcm_byte_writer.sv
// ---------------------------------------------------------------------------
// pcm_byte_writer
// Splits accepted PCM samples into FIFO bytes (low byte first when
// SAMPLE_BYTES=2, high byte only when SAMPLE_BYTES=1) and keeps the sticky
// overflow flag for every byte or sample that had to be dropped.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   pcm_valid_i/data_i PCM sample strobe and value
//   capture_active_i   gate for new samples
//   fifo_full_i        FIFO full flag
//   clr_ovf_i          clears overflow (a concurrent drop still sets it)
//   fifo_wr_en_o/data_o registered FIFO write port
//   overflow_o         sticky drop flag
//   sample_acc_o       one-cycle pulse per accepted sample
//                      (only with PDM_SAMPLE_COUNT_EN)
// ---------------------------------------------------------------------------
module pcm_byte_writer
  import pdm_ctrl_pkg::*;
#(
  parameter int SAMPLE_BYTES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcm_valid_i,
  input  logic [15:0] pcm_data_i,
  input  logic        capture_active_i,
  input  logic        fifo_full_i,
  input  logic        clr_ovf_i,
  output logic        fifo_wr_en_o,
  output logic [7:0]  fifo_wr_data_o,
`ifdef PDM_SAMPLE_COUNT_EN
  output logic        sample_acc_o,
`endif
  output logic        overflow_o
);

  wr_state_t  state_q;
  logic       wr_en_q;
  logic [7:0] wr_data_q;
  logic [7:0] hi_byte_q;
  logic       ovf_q;
`ifdef PDM_SAMPLE_COUNT_EN
  logic       acc_q;
`endif

  // NOTE: state is updated with non-blocking assignments only, so every
  // read in this block sees the value from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= W_IDLE;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      hi_byte_q <= '0;
      ovf_q     <= 1'b0;
`ifdef PDM_SAMPLE_COUNT_EN
      acc_q     <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
`ifdef PDM_SAMPLE_COUNT_EN
      acc_q   <= 1'b0;
`endif
      // Clear first so that a drop in the same cycle wins below.
      if (clr_ovf_i) ovf_q <= 1'b0;

      case (state_q)
        W_IDLE: begin
          if (pcm_valid_i && capture_active_i) begin
            if (!fifo_full_i) begin
              wr_en_q   <= 1'b1;
              wr_data_q <= (SAMPLE_BYTES == 2) ? pcm_data_i[7:0] : pcm_data_i[15:8];
              hi_byte_q <= pcm_data_i[15:8];
`ifdef PDM_SAMPLE_COUNT_EN
              acc_q     <= 1'b1;
`endif
              if (SAMPLE_BYTES == 2) state_q <= W_HI;
            end else begin
              ovf_q <= 1'b1;
            end
          end
        end
        W_HI: begin
          // The high byte is completed even if capture was stopped meanwhile.
          if (!fifo_full_i) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= hi_byte_q;
          end else begin
            ovf_q <= 1'b1;
          end
          // No room to start another sample while finishing this one.
          if (pcm_valid_i) ovf_q <= 1'b1;
          state_q <= W_IDLE;
        end
        default: state_q <= W_IDLE;
      endcase
    end
  end

  assign fifo_wr_en_o   = wr_en_q;
  assign fifo_wr_data_o = wr_data_q;
  assign overflow_o     = ovf_q;
`ifdef PDM_SAMPLE_COUNT_EN
  assign sample_acc_o   = acc_q;
`endif

endmodule

// File: rtl/pdm_capture_ctrl.sv
// ---------------------------------------------------------------------------
// pdm_capture_ctrl
// Command-driven glue between the PCM decimator output, the byte-wide TX
// FIFO and the SPI slave. Decodes host opcodes, gates capture into the FIFO
// through pcm_byte_writer, and preloads every SPI transfer with a FIFO data
// byte, the empty fill byte, or a status/count byte.
// Parameters:
//   SAMPLE_BYTES  bytes written per PCM sample (1 or 2)
//   EMPTY_FILL    TX byte used when the FIFO is empty in DATA mode
//   AUTOSTART     capture_active value after reset
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   bus           pdm_capture_ctrl_if.master (PCM, SPI and FIFO signals)
// Optional feature macro: PDM_SAMPLE_COUNT_EN adds a saturating accepted
// sample counter read out by CMD_COUNT as two transfers (low, then high).
// ---------------------------------------------------------------------------
module pdm_capture_ctrl
  import pdm_ctrl_pkg::*;
#(
  parameter int         SAMPLE_BYTES = 2,
  parameter logic [7:0] EMPTY_FILL   = 8'h00,
  parameter bit         AUTOSTART    = 1'b0
) (
  input logic              clk,
  input logic              rst,
  pdm_capture_ctrl_if.master bus
);

  // Command decode (registered effects appear the cycle after spi_rx_valid)
  logic cmd_start, cmd_stop, cmd_status, cmd_clrerr;
  assign cmd_start  = bus.spi_rx_valid && (bus.spi_rx_data == CMD_START);
  assign cmd_stop   = bus.spi_rx_valid && (bus.spi_rx_data == CMD_STOP);
  assign cmd_status = bus.spi_rx_valid && (bus.spi_rx_data == CMD_STATUS);
  assign cmd_clrerr = bus.spi_rx_valid && (bus.spi_rx_data == CMD_CLRERR);

  logic       active_q;
  tx_mode_t   mode_q;
  rd_state_t  rd_state_q;
  logic [7:0] tx_data_q;
  logic       tx_valid_q;
  logic       rd_en_q;

  logic       wr_en;
  logic [7:0] wr_data;
  logic       overflow;

`ifdef PDM_SAMPLE_COUNT_EN
  logic        cmd_count;
  logic        sample_acc;
  logic [15:0] sample_cnt_q;
  logic [15:0] sample_cnt_d;
  logic [15:0] cnt_snap_q;

  assign cmd_count = bus.spi_rx_valid && (bus.spi_rx_data == CMD_COUNT);
`endif

  pcm_byte_writer #(
    .SAMPLE_BYTES(SAMPLE_BYTES)
  ) u_writer (
    .clk             (clk),
    .rst             (rst),
    .pcm_valid_i     (bus.pcm_valid),
    .pcm_data_i      (bus.pcm_data),
    .capture_active_i(active_q),
    .fifo_full_i     (bus.fifo_full),
    .clr_ovf_i       (cmd_clrerr),
    .fifo_wr_en_o    (wr_en),
    .fifo_wr_data_o  (wr_data),
`ifdef PDM_SAMPLE_COUNT_EN
    .sample_acc_o    (sample_acc),
`endif
    .overflow_o      (overflow)
  );

`ifdef PDM_SAMPLE_COUNT_EN
  // NOTE: every variable assigned in always_comb gets a default first, so
  // no path can leave it unassigned and infer a latch.
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    if (cmd_start && !active_q) begin
      // Restart counting only when capture actually starts.
      sample_cnt_d = '0;
    end else if (sample_acc && (sample_cnt_q != 16'hFFFF)) begin
      sample_cnt_d = sample_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sample_cnt_q <= '0;
    else     sample_cnt_q <= sample_cnt_d;
  end
`endif

  // Read scheduler and command decoder share mode_q, so they live in one
  // block. The command is applied after the transfer logic: a transfer that
  // starts together with a command still uses the old mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q   <= AUTOSTART;
      mode_q     <= DATA;
      rd_state_q <= R_IDLE;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rd_en_q    <= 1'b0;
`ifdef PDM_SAMPLE_COUNT_EN
      cnt_snap_q <= '0;
`endif
    end else begin
      tx_valid_q <= 1'b0;
      rd_en_q    <= 1'b0;

      case (rd_state_q)
        R_IDLE: begin
          if (bus.spi_xfer_start) begin
            if (mode_q == STATUS) begin
              tx_data_q  <= status_byte(active_q, overflow, bus.fifo_full, bus.fifo_empty);
              tx_valid_q <= 1'b1;
              mode_q     <= DATA;
            end
`ifdef PDM_SAMPLE_COUNT_EN
            else if (mode_q == CNT_LO) begin
              tx_data_q  <= cnt_snap_q[7:0];
              tx_valid_q <= 1'b1;
              mode_q     <= CNT_HI;
            end else if (mode_q == CNT_HI) begin
              tx_data_q  <= cnt_snap_q[15:8];
              tx_valid_q <= 1'b1;
              mode_q     <= DATA;
            end
`endif
            else if (bus.fifo_empty) begin
              tx_data_q  <= EMPTY_FILL;
              tx_valid_q <= 1'b1;
            end else begin
              rd_en_q    <= 1'b1;
              rd_state_q <= R_WAIT;
            end
          end
        end
        // FIFO is sampling rd_en this cycle; its data is valid in R_LOAD.
        R_WAIT: rd_state_q <= R_LOAD;
        R_LOAD: begin
          tx_data_q  <= bus.fifo_rd_data;
          tx_valid_q <= 1'b1;
          rd_state_q <= R_IDLE;
        end
        default: rd_state_q <= R_IDLE;
      endcase

      if (cmd_start)  active_q <= 1'b1;
      if (cmd_stop)   active_q <= 1'b0;
      if (cmd_status) mode_q   <= STATUS;
`ifdef PDM_SAMPLE_COUNT_EN
      if (cmd_count) begin
        cnt_snap_q <= sample_cnt_q;
        mode_q     <= CNT_LO;
      end
`endif
    end
  end

  assign bus.spi_tx_data    = tx_data_q;
  assign bus.spi_tx_valid   = tx_valid_q;
  assign bus.fifo_rd_en     = rd_en_q;
  assign bus.fifo_wr_en     = wr_en;
  assign bus.fifo_wr_data   = wr_data;
  assign bus.capture_active = active_q;
  assign bus.overflow       = overflow;

endmodule
